// File: rtl/cve2_fp_pkg.sv
// Shared definitions for the FP writeback scoreboard: source encoding, address width
// and register-file depth derivation.
package cve2_fp_pkg;

   localparam int FP_ADDR_W = 5;

   typedef enum logic {
      WB_FPU = 1'b0,
      WB_LSU = 1'b1
   } wb_src_e;

   function automatic int num_words(input bit rv32e);
      return rv32e ? 16 : 32;
   endfunction

endpackage

// File: rtl/cve2_fp_wb_arb.sv
// Two-way round-robin arbiter between FPU and LSU writeback sources. The pointer only
// moves after a grant made while both sources were requesting.
module cve2_fp_wb_arb
   import cve2_fp_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic fpu_valid,
   input  logic lsu_valid,
   output logic fpu_ready,
   output logic lsu_ready,
   output logic grant_valid,
   output logic grant_lsu
);

   wb_src_e ptr;

   // Valid/ready: a source's data is taken in a cycle where its valid and ready are both
   // high; ready is raised only for the single winner and never without valid.
   always_comb begin
      grant_lsu   = lsu_valid && (!fpu_valid || (ptr == WB_LSU));
      grant_valid = fpu_valid || lsu_valid;
      fpu_ready   = fpu_valid && !grant_lsu;
      lsu_ready   = grant_lsu;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= WB_FPU;
      end else if (fpu_valid && lsu_valid) begin
         ptr <= grant_lsu ? WB_FPU : WB_LSU;
      end
   end

endmodule

// File: rtl/cve2_fp_wb_scoreboard.sv
// FP register-file producer side: pending-destination scoreboard, RAW/WAW hazard
// reporting and a registered single write port shared by FPU and LSU writebacks.
module cve2_fp_wb_scoreboard
   import cve2_fp_pkg::*;
#(
   parameter bit RV32E     = 1'b0,
   parameter int DataWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 issue_valid_i,
   input  logic [4:0]           issue_rd_i,
   output logic                 issue_ready_o,
   input  logic [4:0]           raddr_a_i,
   input  logic [4:0]           raddr_b_i,
   input  logic [4:0]           raddr_c_i,
   output logic                 hazard_o,
   input  logic                 flush_i,
   input  logic                 fpu_wb_valid_i,
   input  logic [4:0]           fpu_wb_addr_i,
   input  logic [DataWidth-1:0] fpu_wb_data_i,
   output logic                 fpu_wb_ready_o,
   input  logic                 lsu_wb_valid_i,
   input  logic [4:0]           lsu_wb_addr_i,
   input  logic [DataWidth-1:0] lsu_wb_data_i,
   output logic                 lsu_wb_ready_o,
   output logic [4:0]           waddr_a_o,
   output logic [DataWidth-1:0] wdata_a_o,
   output logic                 we_a_o,
   output logic                 err_o
);

   localparam int NUM_WORDS = num_words(RV32E);

   logic [31:0]           pending;
   logic [31:0]           pending_d;
   logic                  err_mask;
   logic                  grant_valid;
   logic                  grant_lsu;
   logic [4:0]            wb_addr;
   logic [DataWidth-1:0]  wb_data;
   logic                  wb_write;
   logic                  issue_fire;

   function automatic logic addr_ok(input logic [FP_ADDR_W-1:0] a);
      return (a != '0) && (int'(a) < NUM_WORDS);
   endfunction

   cve2_fp_wb_arb u_arb (
      .clk         (clk_i),
      .rst_n       (rst_ni),
      .fpu_valid   (fpu_wb_valid_i),
      .lsu_valid   (lsu_wb_valid_i),
      .fpu_ready   (fpu_wb_ready_o),
      .lsu_ready   (lsu_wb_ready_o),
      .grant_valid (grant_valid),
      .grant_lsu   (grant_lsu)
   );

   // Invalid addresses never get a pending bit, so plain indexing is safe for hazards.
   always_comb begin
      issue_ready_o = !(addr_ok(issue_rd_i) && pending[issue_rd_i]);
      issue_fire    = issue_valid_i && issue_ready_o && addr_ok(issue_rd_i);
      hazard_o      = pending[raddr_a_i] | pending[raddr_b_i] | pending[raddr_c_i];
      wb_addr       = grant_lsu ? lsu_wb_addr_i : fpu_wb_addr_i;
      wb_data       = grant_lsu ? lsu_wb_data_i : fpu_wb_data_i;
      wb_write      = grant_valid && addr_ok(wb_addr);
   end

   // Clear first, then set, so a same-edge set of the same register wins; flush beats both.
   always_comb begin
      pending_d = pending;
      if (wb_write) pending_d[wb_addr] = 1'b0;
      if (issue_fire) pending_d[issue_rd_i] = 1'b1;
      if (flush_i) pending_d = '0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending  <= '0;
         err_mask <= 1'b0;
         err_o    <= 1'b0;
      end else begin
         pending <= pending_d;
         if (flush_i) begin
            err_mask <= 1'b1;
         end else if (issue_fire) begin
            err_mask <= 1'b0;
         end
         // Writebacks of operations killed by a flush are expected until the next issue.
         if (wb_write && !pending[wb_addr] && !err_mask && !flush_i) begin
            err_o <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         we_a_o    <= 1'b0;
         waddr_a_o <= '0;
         wdata_a_o <= '0;
      end else begin
         we_a_o <= wb_write;
         if (wb_write) begin
            waddr_a_o <= wb_addr;
            wdata_a_o <= wb_data;
         end
      end
   end

endmodule

// File: tb/tb_cve2_fp_wb_scoreboard.sv
// Directed bench for the FP writeback scoreboard (RV32E build, 16 registers).
module tb_cve2_fp_wb_scoreboard;

   localparam int DW = 32;

   logic          clk;
   logic          rst_n;
   logic          issue_valid;
   logic [4:0]    issue_rd;
   logic          issue_ready;
   logic [4:0]    raddr_a;
   logic [4:0]    raddr_b;
   logic [4:0]    raddr_c;
   logic          hazard;
   logic          flush;
   logic          fpu_valid;
   logic [4:0]    fpu_addr;
   logic [DW-1:0] fpu_data;
   logic          fpu_ready;
   logic          lsu_valid;
   logic [4:0]    lsu_addr;
   logic [DW-1:0] lsu_data;
   logic          lsu_ready;
   logic [4:0]    waddr;
   logic [DW-1:0] wdata;
   logic          we;
   logic          err;

   int n_checks = 0;
   int n_fails  = 0;
   logic [4+DW:0] exp_q[$];

   cve2_fp_wb_scoreboard #(.RV32E(1'b1), .DataWidth(DW)) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .issue_valid_i  (issue_valid),
      .issue_rd_i     (issue_rd),
      .issue_ready_o  (issue_ready),
      .raddr_a_i      (raddr_a),
      .raddr_b_i      (raddr_b),
      .raddr_c_i      (raddr_c),
      .hazard_o       (hazard),
      .flush_i        (flush),
      .fpu_wb_valid_i (fpu_valid),
      .fpu_wb_addr_i  (fpu_addr),
      .fpu_wb_data_i  (fpu_data),
      .fpu_wb_ready_o (fpu_ready),
      .lsu_wb_valid_i (lsu_valid),
      .lsu_wb_addr_i  (lsu_addr),
      .lsu_wb_data_i  (lsu_data),
      .lsu_wb_ready_o (lsu_ready),
      .waddr_a_o      (waddr),
      .wdata_a_o      (wdata),
      .we_a_o         (we),
      .err_o          (err)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // scoreboard: every register-file write must match the oldest expected write
   always @(negedge clk) begin
      if (rst_n && we) begin
         if (exp_q.size() == 0) begin
            check("wb_extra_write", 64'(we), 64'(0));
         end else begin
            check("wb_content", 64'({waddr, wdata}), 64'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      issue_valid = 1'b0;
      fpu_valid   = 1'b0;
      lsu_valid   = 1'b0;
      flush       = 1'b0;
   endtask

   task automatic issue(input logic [4:0] rd);
      issue_valid = 1'b1;
      issue_rd    = rd;
      tick();
      issue_valid = 1'b0;
   endtask

   // Single-source writeback; checks the handshake and, when a write is expected, queues it.
   task automatic wb(input bit from_lsu, input logic [4:0] addr, input logic [DW-1:0] data,
                     input bit exp_write);
      if (from_lsu) begin
         lsu_valid = 1'b1; lsu_addr = addr; lsu_data = data;
      end else begin
         fpu_valid = 1'b1; fpu_addr = addr; fpu_data = data;
      end
      if (exp_write) exp_q.push_back({addr, data});
      #1;
      check("wb_ready", 64'({fpu_ready, lsu_ready}), from_lsu ? 64'(2'b01) : 64'(2'b10));
      tick();
      fpu_valid = 1'b0;
      lsu_valid = 1'b0;
   endtask

   logic [4:0] t3_fa [5] = '{5'd1, 5'd3, 5'd3, 5'd6, 5'd6};
   logic [4:0] t3_la [5] = '{5'd2, 5'd2, 5'd4, 5'd4, 5'd0};
   bit         t3_lv [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   bit         t3_win[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

   initial begin
      rst_n = 1'b0;
      idle();
      issue_rd = '0; raddr_a = '0; raddr_b = '0; raddr_c = '0;
      fpu_addr = '0; fpu_data = '0; lsu_addr = '0; lsu_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_we", 64'(we), 64'(0));
      check("rst_waddr", 64'(waddr), 64'(0));
      check("rst_wdata", 64'(wdata), 64'(0));
      check("rst_err", 64'(err), 64'(0));
      check("rst_hazard", 64'(hazard), 64'(0));
      check("rst_issue_ready", 64'(issue_ready), 64'(1));
      rst_n = 1'b1;
      tick();

      // basic issue -> hazard -> FPU writeback
      raddr_a = 5'd5;
      issue(5'd5);
      #1;
      check("t1_hazard_set", 64'(hazard), 64'(1));
      fpu_valid = 1'b1; fpu_addr = 5'd5; fpu_data = 32'h3F80_0000;
      exp_q.push_back({5'd5, 32'h3F80_0000});
      #1;
      check("t1_fpu_ready", 64'(fpu_ready), 64'(1));
      check("t1_hazard_during_hs", 64'(hazard), 64'(1));
      tick();
      fpu_valid = 1'b0;
      #1;
      check("t1_we", 64'(we), 64'(1));
      check("t1_waddr", 64'(waddr), 64'(5));
      check("t1_wdata", 64'(wdata), 64'h3F80_0000);
      check("t1_hazard_clear", 64'(hazard), 64'(0));
      tick();
      check("t1_we_drop", 64'(we), 64'(0));
      check("t1_waddr_hold", 64'(waddr), 64'(5));
      raddr_a = '0;

      // WAW stall, then issue alongside a writeback
      issue(5'd7);
      issue_valid = 1'b1; issue_rd = 5'd7;
      #1;
      check("t2_waw_stall", 64'(issue_ready), 64'(0));
      tick();
      issue_rd = 5'd8;
      fpu_valid = 1'b1; fpu_addr = 5'd7; fpu_data = 32'h4000_0000;
      exp_q.push_back({5'd7, 32'h4000_0000});
      #1;
      check("t2_issue8_ready", 64'(issue_ready), 64'(1));
      check("t2_fpu_ready", 64'(fpu_ready), 64'(1));
      tick();
      idle();
      raddr_b = 5'd8;
      #1;
      check("t2_hazard8", 64'(hazard), 64'(1));
      check("t2_we7", 64'({we, waddr}), 64'({1'b1, 5'd7}));
      raddr_b = 5'd7;
      #1;
      check("t2_no_hazard7", 64'(hazard), 64'(0));
      raddr_b = '0;
      wb(1'b1, 5'd8, 32'hA000_0008, 1'b1);
      check("t2_err_clean", 64'(err), 64'(0));

      // round-robin with both sources requesting
      issue(5'd1); issue(5'd2); issue(5'd3); issue(5'd4); issue(5'd6);
      for (int i = 0; i < 5; i++) begin
         fpu_valid = 1'b1; fpu_addr = t3_fa[i]; fpu_data = 32'hF000_0000 | 32'(t3_fa[i]);
         lsu_valid = t3_lv[i]; lsu_addr = t3_la[i]; lsu_data = 32'hA000_0000 | 32'(t3_la[i]);
         if (t3_win[i]) exp_q.push_back({t3_la[i], 32'hA000_0000 | 32'(t3_la[i])});
         else exp_q.push_back({t3_fa[i], 32'hF000_0000 | 32'(t3_fa[i])});
         #1;
         check($sformatf("t3_grant%0d", i), 64'({fpu_ready, lsu_ready}),
               t3_win[i] ? 64'(2'b01) : 64'(2'b10));
         tick();
         check($sformatf("t3_we%0d", i), 64'(we), 64'(1));
      end
      idle();
      check("t3_err_clean", 64'(err), 64'(0));

      // flush with three pending, late writeback must not flag an error
      issue(5'd11); issue(5'd12); issue(5'd13);
      raddr_a = 5'd11; raddr_b = 5'd12; raddr_c = 5'd13;
      #1;
      check("t5_hazard_pre_flush", 64'(hazard), 64'(1));
      flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd14;
      tick();
      idle();
      #1;
      check("t5_hazard_post_flush", 64'(hazard), 64'(0));
      raddr_a = 5'd14;
      #1;
      check("t5_flushed_issue_dropped", 64'(hazard), 64'(0));
      raddr_a = '0; raddr_b = '0; raddr_c = '0;
      wb(1'b0, 5'd12, 32'h1234_5678, 1'b1);
      check("t5_we12", 64'({we, waddr}), 64'({1'b1, 5'd12}));
      check("t5_err_masked", 64'(err), 64'(0));

      // out-of-range addresses in the 16-entry file
      issue(5'd20);
      raddr_a = 5'd20;
      #1;
      check("t6_rd20_no_hazard", 64'(hazard), 64'(0));
      issue(5'd16);
      raddr_a = 5'd16;
      #1;
      check("t6_rd16_no_hazard", 64'(hazard), 64'(0));
      issue(5'd15);
      raddr_a = 5'd15;
      #1;
      check("t6_rd15_hazard", 64'(hazard), 64'(1));
      raddr_a = '0;
      wb(1'b0, 5'd15, 32'h0000_0F0F, 1'b1);
      check("t6_err_clean", 64'(err), 64'(0));
      wb(1'b0, 5'd20, 32'hDEAD_0020, 1'b0);
      check("t6_no_write20", 64'(we), 64'(0));

      // writeback to a non-pending register, then address 0
      wb(1'b1, 5'd9, 32'hA000_0009, 1'b1);
      check("t4_err_set", 64'(err), 64'(1));
      check("t4_written", 64'({we, waddr}), 64'({1'b1, 5'd9}));
      tick();
      check("t4_err_sticky", 64'(err), 64'(1));
      issue_valid = 1'b1; issue_rd = 5'd0;
      #1;
      check("t4_rd0_ready", 64'(issue_ready), 64'(1));
      tick();
      issue_valid = 1'b0;
      #1;
      check("t4_rd0_no_hazard", 64'(hazard), 64'(0));
      wb(1'b0, 5'd0, 32'h0BAD_0000, 1'b0);
      check("t4_rd0_no_write", 64'(we), 64'(0));
      check("t4_waddr_hold", 64'(waddr), 64'(9));

      // asynchronous reset while a write is staged
      issue(5'd3);
      fpu_valid = 1'b1; fpu_addr = 5'd3; fpu_data = 32'h5555_AAAA;
      tick();
      fpu_valid = 1'b0;
      check("t7_staged", 64'(we), 64'(1));
      rst_n = 1'b0;
      raddr_a = 5'd3;
      #1;
      check("t7_rst_we", 64'(we), 64'(0));
      check("t7_rst_waddr", 64'(waddr), 64'(0));
      check("t7_rst_err", 64'(err), 64'(0));
      tick();
      rst_n = 1'b1;
      issue_valid = 1'b1; issue_rd = 5'd3;
      #1;
      check("t7_ready_after_rst", 64'(issue_ready), 64'(1));
      tick();
      issue_valid = 1'b0;
      #1;
      check("t7_hazard_after_issue", 64'(hazard), 64'(1));
      tick();

      check("wb_q_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/cve2_fp_wb_scoreboard.md
Name: cve2_fp_wb_scoreboard

Overview:
- Producer side of the FP register file write port.
- Tracks outstanding FP destination registers issued to the multi-cycle FPU and to the LSU (FLW).
- Arbitrates the two writeback sources onto the single registered write port (waddr/wdata/we).
- Reports RAW hazards for the three FP read addresses and a WAW stall for issue.

Parameters:
- RV32E, 0, 1 limits the tracked file to 16 entries (NUM_WORDS=16), else 32.
- DataWidth, 32, width of the writeback data path.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  instruction with FP destination issuing this cycle
- issue_rd_i  in  5  FP destination address
- issue_ready_o  out  1  issue accepted (low = WAW stall)
- raddr_a_i / raddr_b_i / raddr_c_i  in  5 each  operand addresses being read
- hazard_o  out  1  any read address has a pending write
- flush_i  in  1  clear all pending marks
- fpu_wb_valid_i  in  1  FPU result valid
- fpu_wb_addr_i  in  5  FPU result destination
- fpu_wb_data_i  in  DataWidth  FPU result data
- fpu_wb_ready_o  out  1  FPU result accepted
- lsu_wb_valid_i / lsu_wb_addr_i / lsu_wb_data_i / lsu_wb_ready_o  as FPU, for load data
- waddr_a_o  out  5  register file write address
- wdata_a_o  out  DataWidth  register file write data
- we_a_o  out  1  register file write enable
- err_o  out  1  sticky: writeback to a non-pending register

Behaviour:
- Clocking and reset: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values:
  - pending[] = 0; we_a_o = 0; waddr_a_o = 0; wdata_a_o = 0.
  - err_o = 0; round-robin pointer = FPU.
- Address range:
  - Address valid iff addr < NUM_WORDS and addr != 0.
  - Invalid addresses are never pending and never written (we_a_o stays 0).
  - A valid/ready handshake still completes for invalid addresses.
- Issue:
  - issue_ready_o = !(issue_rd_i valid-address && pending[issue_rd_i]); combinational.
  - On issue_valid_i && issue_ready_o with a valid address, pending[rd] is set at the next edge.
  - WAW rule is conservative: a clear of rd in the same cycle does not lift the stall.
- Hazard: hazard_o = OR over a/b/c of pending[raddr_x]; combinational; address 0 never hazards.
- Arbitration:
  - One winner per cycle. The write stage has no backpressure, so the winner is always accepted.
  - Winner's ready_o = 1; loser's ready_o = 0. Ready is combinational from the valids and the pointer.
  - Only one valid: that source wins.
  - Both valid: the pointer decides. After a both-valid grant, the pointer moves to the other source.
- Write stage, 1-cycle latency:
  - On a handshake at edge N, we_a_o / waddr_a_o / wdata_a_o are driven during cycle N+1.
  - With no handshake, we_a_o = 0 and waddr/wdata hold their last value.
- Clear:
  - pending[addr] clears at the edge where the handshake is accepted, so the hazard drops one cycle before the RF is written.
  - The consumer reads through the RF next cycle; the bypass is the core's responsibility.
- Simultaneous set and clear of the same address at one edge: set wins (a new issue after a stall).
  - This cannot occur through the WAW stall but must be defined.
- Error: a writeback handshake to a valid address with pending=0 sets err_o (sticky until reset); the data is still written.
- Flush:
  - flush_i clears all pending bits at the edge, taking priority over sets in the same cycle; any issue that cycle is dropped.
  - Writebacks after a flush are still written and do not set err_o. An err-mask flag is set by flush and cleared when the scoreboard next becomes non-empty through an issue.
- Reset mid-operation: all state returns to reset values immediately; an in-flight write is lost.

Decomposition:
- Shared package cve2_fp_pkg holds:
  - wb_src_e enum {WB_FPU, WB_LSU};
  - FP_ADDR_W = 5;
  - the NUM_WORDS derivation function from RV32E.
- Sub-module cve2_fp_wb_arb: 2-way round-robin arbiter (valids, pointer flop, grant/ready).
- Scoreboard, hazard logic and write stage stay in the top module.

Test Plan:
- Issue rd=5, then raddr_a=5 -> hazard_o=1. FPU wb addr=5 data=0x3F800000 -> ready same cycle; next cycle we_a_o=1, waddr=5, wdata=0x3F800000; hazard_o=0 from the cycle after the handshake.
- Pending rd=7, issue rd=7 -> issue_ready_o=0, pending unchanged. Issue rd=8 in the same cycle as the wb of 7 -> accepted; hazard on 8 follows.
- FPU and LSU both valid for 4 cycles (addrs 1,2) -> grants alternate FPU, LSU, FPU, LSU; we_a_o high 4 consecutive cycles with matching addr/data.
- LSU wb to addr 9 with nothing pending -> err_o=1 and stays 1; RF still written. Issue/wb to addr 0 -> no pending, we_a_o=0, handshake completes.
- RV32E=1: issue rd=20 -> never pending, hazard_o=0. Flush with 3 pending -> all hazards 0 next cycle; a later wb to one of them -> written, err_o stays 0.
- Assert rst_ni low while a write is staged -> we_a_o=0 and pending all 0 asynchronously; after release, first issue behaves normally.
